// File: rtl/accum_divider_if.sv
// Handshake and operand bus for the accum_divider.
// Control logic drives the operands and start; the divider returns its status and results.
interface accum_divider_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      start;
    logic [2*DATA_WIDTH-1:0]   dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]     remainder;
    logic                      div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/accum_divider.sv
// Restoring shift-subtract divider: a 2W-bit accumulated sum is divided by a W-bit count.
// One quotient bit is retired per clock. Results are held in output registers, separate from the working state.
module accum_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    accum_divider_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(2*W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_n;
    logic [W-1:0]    prem;
    logic [2*W-1:0]  dvd;
    logic [W-1:0]    dsr;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  quotient_r;
    logic [W-1:0]    remainder_r;
    logic            dbz_r;

    logic [W:0]      shifted;
    logic [W-1:0]    diff;
    logic [W-1:0]    prem_step;
    logic [2*W-1:0]  dvd_step;
    logic            fits;
    logic            last;
    logic            accept;
    logic            zero_div;

    // The shifted partial remainder is W+1 bits wide, so the compare cannot overflow. Any difference
    // that is kept is smaller than the divisor, which lets it be stored back in W bits.
    // Quotient bits shift into the dividend register from the bottom as dividend bits leave at the top.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        zero_div   = (bus.divisor == '0);
        shifted    = {prem, dvd[2*W-1]};
        fits       = (shifted >= {1'b0, dsr});
        diff       = shifted[W-1:0] - dsr;
        prem_step  = fits ? diff : shifted[W-1:0];
        dvd_step   = {dvd[2*W-2:0], fits};
        last       = (cnt == CW'(1));
        case (state)
            S_IDLE: accept = bus.start;
            S_RUN: begin
                bus.busy = 1'b1;
                if (last)
                    state_n = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                accept   = bus.start;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (accept)
            state_n = zero_div ? S_DONE : S_RUN;
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // A divide by zero finishes on the accepting edge. A normal operation publishes its results only on the final iteration.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prem        <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            prem <= '0;
            dvd  <= bus.dividend;
            dsr  <= bus.divisor;
            cnt  <= CW'(2*W);
            if (zero_div) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend[W-1:0];
                dbz_r       <= 1'b1;
            end else begin
                dbz_r <= 1'b0;
            end
        end else if (state == S_RUN) begin
            prem <= prem_step;
            dvd  <= dvd_step;
            cnt  <= cnt - CW'(1);
            if (last) begin
                quotient_r  <= dvd_step;
                remainder_r <= prem_step;
            end
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_accum_divider.sv
// Self-checking bench for accum_divider at DATA_WIDTH 8 and 32.
// Checks use directed cases plus random operands scored against a plain arithmetic model.
module tb_accum_divider;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    accum_divider_if #(.DATA_WIDTH(8))  b8();
    accum_divider_if #(.DATA_WIDTH(32)) b32();

    accum_divider #(.DATA_WIDTH(8))  dut8  (.Clk(Clk), .Rst(Rst), .bus(b8.slave));
    accum_divider #(.DATA_WIDTH(32)) dut32 (.Clk(Clk), .Rst(Rst), .bus(b32.slave));

    always #5 Clk = ~Clk;

    // Reference: floor division and modulo, or the all-ones/low-bits result when the divisor is zero.
    function automatic void ref_div(input int w, input longint unsigned a, input longint unsigned d,
                                    output longint unsigned q, output longint unsigned r, output bit z);
        longint unsigned qmask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        longint unsigned rmask = (64'd1 << w) - 64'd1;
        if (d == 0) begin
            q = qmask; r = a & rmask; z = 1'b1;
        end else begin
            q = a / d; r = a % d; z = 1'b0;
        end
    endfunction

    // Called on a negedge. lat counts the edges from the accepting edge to the edge where done rises.
    task automatic run_op8(input logic [15:0] a, input logic [7:0] d, output int lat, output int busyCnt,
                           output longint unsigned q, output longint unsigned r, output logic z);
        b8.start = 1'b1; b8.dividend = a; b8.divisor = d;
        @(negedge Clk);
        b8.start = 1'b0;
        lat = 0; busyCnt = 0;
        while (b8.done !== 1'b1 && lat < 40) begin
            if (b8.busy === 1'b1) busyCnt++;
            @(negedge Clk);
            lat++;
        end
        q = 64'(b8.quotient); r = 64'(b8.remainder); z = b8.div_by_zero;
    endtask

    task automatic run_op32(input logic [63:0] a, input logic [31:0] d, output int lat, output int busyCnt,
                            output longint unsigned q, output longint unsigned r, output logic z);
        b32.start = 1'b1; b32.dividend = a; b32.divisor = d;
        @(negedge Clk);
        b32.start = 1'b0;
        lat = 0; busyCnt = 0;
        while (b32.done !== 1'b1 && lat < 140) begin
            if (b32.busy === 1'b1) busyCnt++;
            @(negedge Clk);
            lat++;
        end
        q = 64'(b32.quotient); r = 64'(b32.remainder); z = b32.div_by_zero;
    endtask

    task automatic applyStimulus_idle();
        b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b32.start = 1'b0; b32.dividend = '0; b32.divisor = '0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        total++; if (b8.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", b8.busy); end
        total++; if (b8.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", b8.done); end
        total++; if (b8.quotient !== 16'd0) begin bad++; $display("[TB] FAIL reset_quotient got=%0h want=0", b8.quotient); end
        total++; if (b8.remainder !== 8'd0) begin bad++; $display("[TB] FAIL reset_remainder got=%0h want=0", b8.remainder); end
        total++; if (b8.div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_dbz got=%0b want=0", b8.div_by_zero); end
        total++; if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_wide busy=%0b done=%0b want=0/0", b32.busy, b32.done); end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        int lat, bc; longint unsigned q, r; logic z;
        run_op8(16'd1000, 8'd7, lat, bc, q, r, z);
        total++; if (q !== 64'd142) begin bad++; $display("[TB] FAIL basic_q got=%0d want=142", q); end
        total++; if (r !== 64'd6) begin bad++; $display("[TB] FAIL basic_r got=%0d want=6", r); end
        total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL basic_dbz got=%0b want=0", z); end
        total++; if (lat != 16) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=16", lat); end
        total++; if (bc != 16) begin bad++; $display("[TB] FAIL basic_busy_cycles got=%0d want=16", bc); end
        @(negedge Clk);
        total++; if (b8.done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_pulse got=%0b want=0", b8.done); end
    endtask

    task automatic test_extremes();
        logic [15:0] av [4] = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd0};
        logic [7:0]  dv [4] = '{8'd1, 8'hFF, 8'd9, 8'd13};
        longint unsigned qv [4] = '{64'hFFFF, 64'd257, 64'd0, 64'd0};
        longint unsigned rv [4] = '{64'd0, 64'd0, 64'd5, 64'd0};
        int lat, bc; longint unsigned q, r; logic z;
        for (int i = 0; i < 4; i++) begin
            run_op8(av[i], dv[i], lat, bc, q, r, z);
            total++; if (q !== qv[i]) begin bad++; $display("[TB] FAIL extreme%0d_q got=%0d want=%0d", i, q, qv[i]); end
            total++; if (r !== rv[i]) begin bad++; $display("[TB] FAIL extreme%0d_r got=%0d want=%0d", i, r, rv[i]); end
            total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL extreme%0d_dbz got=%0b want=0", i, z); end
        end
        @(negedge Clk);
    endtask

    task automatic test_div_by_zero();
        int lat, bc; longint unsigned q, r; logic z;
        run_op8(16'h1234, 8'd0, lat, bc, q, r, z);
        total++; if (q !== 64'hFFFF) begin bad++; $display("[TB] FAIL dbz_q got=%0h want=ffff", q); end
        total++; if (r !== 64'h34) begin bad++; $display("[TB] FAIL dbz_r got=%0h want=34", r); end
        total++; if (z !== 1'b1) begin bad++; $display("[TB] FAIL dbz_flag got=%0b want=1", z); end
        total++; if (lat != 0) begin bad++; $display("[TB] FAIL dbz_latency got=%0d want=0", lat); end
        total++; if (bc != 0) begin bad++; $display("[TB] FAIL dbz_busy_cycles got=%0d want=0", bc); end
        @(negedge Clk);
        run_op8(16'd100, 8'd10, lat, bc, q, r, z);
        total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL dbz_clear got=%0b want=0", z); end
        total++; if (q !== 64'd10 || r !== 64'd0) begin bad++; $display("[TB] FAIL dbz_next got=%0d/%0d want=10/0", q, r); end
        @(negedge Clk);
    endtask

    // A start raised mid-run with different operands must change neither the result nor the number of done pulses.
    task automatic test_ignore_start();
        int dones = 0, doneAt = -1;
        longint unsigned q = 0, r = 0;
        b8.start = 1'b1; b8.dividend = 16'd1000; b8.divisor = 8'd7;
        @(negedge Clk);
        b8.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (b8.done === 1'b1) begin
                dones++; doneAt = c; q = 64'(b8.quotient); r = 64'(b8.remainder);
            end
            if (c == 5) begin b8.start = 1'b1; b8.dividend = 16'd50; b8.divisor = 8'd3; end
            if (c == 6) b8.start = 1'b0;
            @(negedge Clk);
        end
        total++; if (dones != 1) begin bad++; $display("[TB] FAIL ignore_done_count got=%0d want=1", dones); end
        total++; if (doneAt != 17) begin bad++; $display("[TB] FAIL ignore_done_time got=%0d want=17", doneAt); end
        total++; if (q !== 64'd142 || r !== 64'd6) begin bad++; $display("[TB] FAIL ignore_result got=%0d/%0d want=142/6", q, r); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; longint unsigned q, r; logic z;
        run_op8(16'd1000, 8'd7, lat, bc, q, r, z);
        total++; if (q !== 64'd142 || r !== 64'd6) begin bad++; $display("[TB] FAIL b2b_first got=%0d/%0d want=142/6", q, r); end
        run_op8(16'd50, 8'd3, lat, bc, q, r, z);
        total++; if (lat != 16) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=16", lat); end
        total++; if (bc != 16) begin bad++; $display("[TB] FAIL b2b_busy_cycles got=%0d want=16", bc); end
        total++; if (q !== 64'd16 || r !== 64'd2) begin bad++; $display("[TB] FAIL b2b_second got=%0d/%0d want=16/2", q, r); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, dones = 0; longint unsigned q, r; logic z;
        b8.start = 1'b1; b8.dividend = 16'd1000; b8.divisor = 8'd7;
        @(negedge Clk);
        b8.start = 1'b0;
        repeat (7) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        total++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_status busy=%0b done=%0b want=0/0", b8.busy, b8.done); end
        total++; if (b8.quotient !== 16'd0 || b8.remainder !== 8'd0 || b8.div_by_zero !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_outputs got=%0h/%0h/%0b want=0/0/0", b8.quotient, b8.remainder, b8.div_by_zero);
        end
        for (int c = 0; c < 30; c++) begin
            if (b8.done === 1'b1) dones++;
            @(negedge Clk);
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL midrst_no_done got=%0d want=0", dones); end
        run_op8(16'd200, 8'd9, lat, bc, q, r, z);
        total++; if (q !== 64'd22 || r !== 64'd2 || lat != 16) begin bad++; $display("[TB] FAIL midrst_fresh got=%0d/%0d lat=%0d want=22/2 lat=16", q, r, lat); end
        @(negedge Clk);
    endtask

    task automatic test_random8();
        int lat, bc; longint unsigned q, r, mq, mr; logic z; bit mz;
        logic [15:0] a; logic [7:0] d;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom) >> $urandom_range(0, 12);
            d = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ref_div(8, 64'(a), 64'(d), mq, mr, mz);
            run_op8(a, d, lat, bc, q, r, z);
            total++; if (q !== mq || r !== mr || z !== mz) begin
                bad++; $display("[TB] FAIL rand8_result %0d/%0d got=%0d r%0d z%0b want=%0d r%0d z%0b", a, d, q, r, z, mq, mr, mz);
            end
            total++; if (lat != (mz ? 0 : 16) || bc != (mz ? 0 : 16)) begin
                bad++; $display("[TB] FAIL rand8_timing %0d/%0d got=lat%0d busy%0d want=%0d", a, d, lat, bc, mz ? 0 : 16);
            end
            if ($urandom_range(0, 3) == 0) @(negedge Clk);
        end
        @(negedge Clk);
    endtask

    task automatic test_random32();
        int lat, bc; longint unsigned q, r, mq, mr; logic z; bit mz;
        logic [63:0] a; logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            a = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
            d = ($urandom_range(0, 9) == 0) ? 32'd0 : (32'($urandom) >> $urandom_range(0, 31));
            if (d == 0 && $urandom_range(0, 1) == 0) d = 32'd1;
            ref_div(32, a, 64'(d), mq, mr, mz);
            run_op32(a, d, lat, bc, q, r, z);
            total++; if (q !== mq || r !== mr || z !== mz) begin
                bad++; $display("[TB] FAIL rand32_result %0h/%0h got=%0h r%0h z%0b want=%0h r%0h z%0b", a, d, q, r, z, mq, mr, mz);
            end
            total++; if (lat != (mz ? 0 : 64) || bc != (mz ? 0 : 64)) begin
                bad++; $display("[TB] FAIL rand32_timing %0h/%0h got=lat%0d busy%0d want=%0d", a, d, lat, bc, mz ? 0 : 64);
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        applyStimulus_idle();
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random8();
        test_random32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
